// File: rtl/mmio_led_pkg.sv
// Shared register map, control-bit positions and bus FSM encoding for the
// memory-mapped PWM LED controller.
package mmio_led_pkg;

  localparam int WINDOW_BYTES = 32;
  localparam int OFF_W        = $clog2(WINDOW_BYTES);

  localparam logic [OFF_W-1:0] DUTY_BASE  = 5'h00;
  localparam logic [OFF_W-1:0] CTRL_OFF   = 5'h10;
  localparam logic [OFF_W-1:0] BLINK_OFF  = 5'h11;
  localparam logic [OFF_W-1:0] STATUS_OFF = 5'h12;

  localparam int EN_BIT       = 0;
  localparam int BLINK_EN_BIT = 1;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

endpackage

// File: rtl/led_pwm_timebase.sv
// Free-running PWM timebase: prescaler, PWM counter with period_end strobe,
// and the blink counter that toggles the blink phase every blink_period periods.
module led_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                blink_en,
  input  logic [7:0]          blink_period,
  input  logic                period_clr,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_end,
  output logic                phase
);

  localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [7:0]          blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                tick;

  // NOTE: every signal assigned here gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    tick        = (psc_q == PSC_LAST);
    psc_d       = tick ? '0 : psc_q + 1'b1;
    pwm_d       = tick ? pwm_q + 1'b1 : pwm_q;
    period_end  = tick && (pwm_q == '1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (!blink_en || (blink_period == 8'd0)) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b1;
    end else if (period_clr) begin
      blink_cnt_d = 8'd0;
    end else if (period_end) begin
      // >= rather than == so a shortened period can never overrun past its end.
      if (blink_cnt_q >= blink_period - 8'd1) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psc_q       <= '0;
      pwm_q       <= '0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b1;
    end else begin
      psc_q       <= psc_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign pwm_cnt = pwm_q;
  assign phase   = phase_q;

endmodule

// File: rtl/mmio_pwm_led.sv
// Memory-mapped LED controller: per-channel PWM duty, global enable, hardware
// blink and readback on the byte-wide MMIO bus, driving the LED pins directly.
module mmio_pwm_led
  import mmio_led_pkg::*;
#(
  parameter int          NUM_CH     = 6,
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          PWM_BITS   = 8,
  parameter int          PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       mmio_addr,
  input  logic [7:0]        mmio_data,
  input  logic              mmio_we,
  input  logic              mmio_req,
  output logic              mmio_done,
  output logic [7:0]        mmio_rdata,
  output logic [NUM_CH-1:0] led
);

  // Reset asserts immediately but releases two clocks later, aligned to the clock.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [1:0]          ctrl_q;
  logic [7:0]          blink_period_q;
  logic [7:0]          rdata_q;
  logic [NUM_CH-1:0]   led_q;
  logic [NUM_CH-1:0]   on;
  bus_state_e          state_q, state_d;

  logic [OFF_W-1:0]    offset;
  logic                hit, accept, wr_acc, period_clr;
  logic [7:0]          rd_val;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end, phase;

  assign offset     = mmio_addr[OFF_W-1:0];
  assign hit        = (mmio_addr[15:OFF_W] == BASE_ADDR[15:OFF_W]);
  assign accept     = mmio_req && hit && (state_q == BUS_IDLE);
  assign wr_acc     = accept && mmio_we;
  assign period_clr = wr_acc && (offset == BLINK_OFF);

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clock        (clock),
    .reset_n      (rst_n),
    .blink_en     (ctrl_q[BLINK_EN_BIT]),
    .blink_period (blink_period_q),
    .period_clr   (period_clr),
    .pwm_cnt      (pwm_cnt),
    .period_end   (period_end),
    .phase        (phase)
  );

  // Bus FSM: state register, next state, outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    if (state_q == BUS_IDLE && accept) state_d = BUS_ACK;
  end

  always_comb begin
    mmio_done = (state_q == BUS_ACK);
  end

  // NOTE: the duty bank is a small flop array that must read 0 after reset, so it sits in the reset branch; a RAM-style array could not.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
      ctrl_q         <= 2'b01;
      blink_period_q <= 8'd0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (offset == DUTY_BASE + OFF_W'(i)) duty_q[i] <= PWM_BITS'(mmio_data);
      end
      if (offset == CTRL_OFF)  ctrl_q         <= mmio_data[1:0];
      if (offset == BLINK_OFF) blink_period_q <= mmio_data;
    end
  end

  always_comb begin
    rd_val = 8'd0;
    case (offset)
      CTRL_OFF:   rd_val = {6'd0, ctrl_q};
      BLINK_OFF:  rd_val = blink_period_q;
      STATUS_OFF: rd_val = {7'd0, phase};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (offset == DUTY_BASE + OFF_W'(i)) rd_val = 8'(duty_q[i]);
        end
      end
    endcase
  end

  // Read data lives only in the acknowledge cycle and is 0 otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                  rdata_q <= 8'd0;
    else if (accept && !mmio_we) rdata_q <= rd_val;
    else                         rdata_q <= 8'd0;
  end

  // All-ones duty is forced fully on so there is no 1/2^PWM_BITS dark slot.
  always_comb begin
    on = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      on[ch] = ctrl_q[EN_BIT] && phase &&
               ((duty_q[ch] == '1) || (pwm_cnt < duty_q[ch]));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) led_q <= {NUM_CH{ACTIVE_LOW}};
    else        led_q <= on ^ {NUM_CH{ACTIVE_LOW}};
  end

  assign mmio_rdata = rdata_q;
  assign led        = led_q;

endmodule
